cache_ctrl: RTL
===============

// Module: cache_ctrl
// PURPOSE
//  Cache controller sitting directly upstream of one cache set: accepts CPU
//  single-word read/write requests and sequences the set's compare/access ops.
//  On a miss it writes back the dirty victim block, refills it from memory and
//  replays the lookup, then completes the CPU request.
// PARAMETERS
//  TAG_W   5   tag width; matches the set's tag_in/tag_out
//  WORD_W  2   word-select width; block holds 2**WORD_W words
//  DATA_W  16  data word width
// PORTS
//  clk           input   1              rising-edge clock
//  rst           input   1              asynchronous, active-low reset
//  cpu_req       input   1              request valid; sampled only in IDLE
//  cpu_wr        input   1              1 = write, 0 = read
//  cpu_addr      input   TAG_W+WORD_W   {tag, word}
//  cpu_wdata     input   DATA_W         write data
//  cpu_rdata     output  DATA_W         read data, valid while cpu_ack=1
//  cpu_ack       output  1              one-cycle completion pulse
//  cpu_busy      output  1              high from acceptance until cpu_ack
//  set_enable    output  1              set transaction strobe (level)
//  set_comp      output  1              1 = compare op, 0 = access op
//  set_write     output  1              set write select
//  set_word      output  WORD_W         word select
//  set_tag       output  TAG_W          tag_in to set
//  set_data      output  DATA_W         data_in to set
//  set_valid     output  1              valid_in to set
//  set_hit       input   1              set hit flag
//  set_dirty     input   1              set dirty_out
//  set_valid_out input   1              set valid_out
//  set_tag_out   input   TAG_W          set tag_out (access read)
//  set_data_out  input   DATA_W         set data_out
//  set_ack       input   1              set transaction done
//  mem_req       output  1              memory request (level)
//  mem_wr        output  1              1 = write, 0 = read
//  mem_addr      output  TAG_W+WORD_W   {tag, word}
//  mem_wdata     output  DATA_W         write data
//  mem_rdata     input   DATA_W         read data, valid with mem_ack
//  mem_ack       input   1              one-cycle memory completion
// BEHAVIOUR
//  - Reset (rst=0, async): every output 0, FSM=IDLE, counter k=0, latched
//    request cleared; any set/mem transaction is abandoned.
//  - IDLE: cpu_req=1 latches cpu_wr/addr/wdata, cpu_busy=1 next cycle, go LOOKUP.
//  - Set handshake: drive set_* stable with set_enable=1 until set_ack=1;
//    capture set outputs that cycle; then set_enable=0 for exactly one GAP cycle
//    before the next set op (the set responds to enable edges).
//  - Mem handshake: mem_req=1 with stable addr/wdata until mem_ack=1; drop
//    mem_req next cycle, keep it low >=1 cycle.
//  - LOOKUP: compare-read (comp=1, write=0) at latched tag/word.
//    hit = set_hit & set_valid_out. Read hit -> DONE with rdata=set_data_out.
//    Write hit -> WR_HIT. Miss: if set_valid_out & set_dirty -> WB_RD (k=0),
//    else FILL_MEM (k=0).
//  - WR_HIT: compare-write with cpu_wdata -> DONE (set marks block dirty).
//  - WB_RD: access-read word k; capture victim tag (k=0) and data -> WB_MEM.
//  - WB_MEM: mem write {victim_tag,k}; k==max -> FILL_MEM with k=0,
//    else k+1 -> WB_RD.
//  - FILL_MEM: mem read {req_tag,k} -> FILL_WR with captured mem_rdata.
//  - FILL_WR: access-write word k, tag=req_tag, set_valid=1; k==max -> LOOKUP
//    (replay, guaranteed hit), else k+1 -> FILL_MEM.
//  - DONE: cpu_ack=1 for one cycle, cpu_busy=0; cpu_rdata holds until the
//    next ack. A cpu_req high during DONE is not accepted; it is sampled in
//    IDLE on the following cycle.
//  - k is WORD_W bits; wraps to 0 on the max->next transition. Writeback always
//    completes before any refill read is issued.
//  - Latency: read hit = 3 cycles from accept to ack (enable, ack, DONE);
//    miss adds one set op per word (plus writeback ops if dirty) and the
//    memory latency.
// TESTING
//  1. Hold rst=0 mid-run -> all outputs 0 immediately; FSM in IDLE after
//     release.
//  2. Cold read tag 5'h03 word 2 (set valid_out=0) -> no mem writes; mem reads
//     at 0x0C..0x0F return 0xA000..0xA003; 4 access writes; replay;
//     cpu_rdata=0xA002 with cpu_ack.
//  3. Write 0xBEEF to tag 03 word 1 on a valid block -> compare-read hit, then
//     compare-write; no mem_req; a later read returns 0xBEEF.
//  4. Read tag 5'h07 word 0 with dirty block tag 03 -> 4 mem writes at
//     0x0C..0x0F with data A000, BEEF, A002, A003, then 4 reads at
//     0x1C..0x1F.
//  5. Assert rst during FILL_MEM k=2 -> mem_req drops at once; a new read
//     afterwards restarts from LOOKUP.
//  6. Hold cpu_req=1 across cpu_ack -> second request accepted one cycle after
//     ack; set_enable is low for >=1 cycle between ops.

Source files
------------

// File: rtl/cache_ctrl.sv
// Cache controller for a single cache set. It takes one CPU word request at a
// time and runs the set's compare/access operations. On a miss it writes back a
// dirty victim block, refills the block word by word from memory, and then
// replays the lookup.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cpu_req
// LOOKUP   | compare-read at the requested tag/word
// WR_HIT   | compare-write of the CPU data (the set marks the block dirty)
// WB_RD    | access-read of victim word k
// WB_MEM   | memory write of victim word k
// FILL_MEM | memory read of requested block word k
// FILL_WR  | access-write of refill word k (valid=1)
// DONE     | one-cycle cpu_ack
module cache_ctrl #(
  parameter int TAG_W  = 5,
  parameter int WORD_W = 2,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_wr,
  input  logic [TAG_W+WORD_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ack,
  output logic                      cpu_busy,
  output logic                      set_enable,
  output logic                      set_comp,
  output logic                      set_write,
  output logic [WORD_W-1:0]         set_word,
  output logic [TAG_W-1:0]          set_tag,
  output logic [DATA_W-1:0]         set_data,
  output logic                      set_valid,
  input  logic                      set_hit,
  input  logic                      set_dirty,
  input  logic                      set_valid_out,
  input  logic [TAG_W-1:0]          set_tag_out,
  input  logic [DATA_W-1:0]         set_data_out,
  input  logic                      set_ack,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [TAG_W+WORD_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WR_HIT, S_WB_RD, S_WB_MEM, S_FILL_MEM, S_FILL_WR, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                req_wr;
  logic [TAG_W-1:0]    req_tag;
  logic [WORD_W-1:0]   req_word;
  logic [DATA_W-1:0]   req_wdata;
  logic [TAG_W-1:0]    victim_tag;
  logic [DATA_W-1:0]   word_buf;
  logic [DATA_W-1:0]   rdata_q;
  logic [WORD_W-1:0]   k;
  logic                gap;
  logic                set_done, mem_done, lookup_hit, k_max;

  // gap forces one idle cycle on both strobes after any completed transaction
  assign set_done   = set_enable & set_ack;
  assign mem_done   = mem_req & mem_ack;
  assign lookup_hit = set_hit & set_valid_out;
  assign k_max      = &k;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (set_done) begin
          if (lookup_hit)                     state_nxt = req_wr ? S_WR_HIT : S_DONE;
          else if (set_valid_out & set_dirty) state_nxt = S_WB_RD;
          else                                state_nxt = S_FILL_MEM;
        end
      end
      S_WR_HIT:   if (set_done) state_nxt = S_DONE;
      S_WB_RD:    if (set_done) state_nxt = S_WB_MEM;
      S_WB_MEM:   if (mem_done) state_nxt = k_max ? S_FILL_MEM : S_WB_RD;
      S_FILL_MEM: if (mem_done) state_nxt = S_FILL_WR;
      S_FILL_WR:  if (set_done) state_nxt = k_max ? S_LOOKUP : S_FILL_MEM;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Request latch, word counter, victim/refill capture and read-data holding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wr     <= 1'b0;
      req_tag    <= '0;
      req_word   <= '0;
      req_wdata  <= '0;
      victim_tag <= '0;
      word_buf   <= '0;
      rdata_q    <= '0;
      k          <= '0;
      gap        <= 1'b0;
    end else begin
      gap <= set_done | mem_done;
      if (state == S_IDLE && cpu_req) begin
        req_wr    <= cpu_wr;
        req_tag   <= cpu_addr[TAG_W+WORD_W-1:WORD_W];
        req_word  <= cpu_addr[WORD_W-1:0];
        req_wdata <= cpu_wdata;
      end
      case (state)
        S_LOOKUP: if (set_done) begin
          k <= '0;
          if (lookup_hit && !req_wr) rdata_q <= set_data_out;
        end
        S_WB_RD: if (set_done) begin
          if (k == '0) victim_tag <= set_tag_out;
          word_buf <= set_data_out;
        end
        S_WB_MEM:   if (mem_done) k <= k + 1'b1;
        S_FILL_MEM: if (mem_done) word_buf <= mem_rdata;
        S_FILL_WR:  if (set_done) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode; everything is zero outside the state that owns it
  always_comb begin
    cpu_rdata  = rdata_q;
    cpu_ack    = 1'b0;
    cpu_busy   = 1'b0;
    set_enable = 1'b0;
    set_comp   = 1'b0;
    set_write  = 1'b0;
    set_word   = '0;
    set_tag    = '0;
    set_data   = '0;
    set_valid  = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      S_LOOKUP: begin
        cpu_busy   = 1'b1;
        set_enable = !gap;
        set_comp   = 1'b1;
        set_word   = req_word;
        set_tag    = req_tag;
      end
      S_WR_HIT: begin
        cpu_busy   = 1'b1;
        set_enable = !gap;
        set_comp   = 1'b1;
        set_write  = 1'b1;
        set_word   = req_word;
        set_tag    = req_tag;
        set_data   = req_wdata;
        set_valid  = 1'b1;
      end
      S_WB_RD: begin
        cpu_busy   = 1'b1;
        set_enable = !gap;
        set_word   = k;
      end
      S_WB_MEM: begin
        cpu_busy  = 1'b1;
        mem_req   = !gap;
        mem_wr    = 1'b1;
        mem_addr  = {victim_tag, k};
        mem_wdata = word_buf;
      end
      S_FILL_MEM: begin
        cpu_busy = 1'b1;
        mem_req  = !gap;
        mem_addr = {req_tag, k};
      end
      S_FILL_WR: begin
        cpu_busy   = 1'b1;
        set_enable = !gap;
        set_write  = 1'b1;
        set_word   = k;
        set_tag    = req_tag;
        set_data   = word_buf;
        set_valid  = 1'b1;
      end
      S_DONE: cpu_ack = 1'b1;
      default: ;
    endcase
  end

endmodule
